// File: rtl/ps2_frame_rx_if.sv
// PS/2 receive-path bundle: raw keyboard pins in, validated byte and status strobes out.
interface ps2_frame_rx_if;
    logic       kbd_clk;
    logic       kbd_dat;
    logic [7:0] dout;
    logic       dout_new;
    logic       parity_err;
    logic       frame_err;

    // Pin driver / byte consumer side
    modport master (
        output kbd_clk,
        output kbd_dat,
        input  dout,
        input  dout_new,
        input  parity_err,
        input  frame_err
    );

    // Receiver side
    modport slave (
        input  kbd_clk,
        input  kbd_dat,
        output dout,
        output dout_new,
        output parity_err,
        output frame_err
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchronizes and de-glitches the pins,
// deserializes 11-bit frames and emits one strobe per terminated frame.
module ps2_frame_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          resetN,
    ps2_frame_rx_if.slave bus
);

    localparam logic [3:0]  FILT_LAST = 4'(FILTER_LEN - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Input conditioning state
    logic [1:0] clk_sync_q, clk_sync_d;
    logic [1:0] dat_sync_q, dat_sync_d;
    logic [3:0] filt_cnt_q, filt_cnt_d;
    logic       clk_filt_q, clk_filt_d;
    logic       clk_filt_dly_q, clk_filt_dly_d;

    logic       fall;
    logic       dat_s;

    // Frame state
    state_t      state_q;
    logic [7:0]  shreg_q;
    logic [2:0]  bit_cnt_q;
    logic        par_q;
    logic [15:0] tmo_cnt_q;
    logic [7:0]  dout_q;
    logic        dout_new_q;
    logic        parity_err_q;
    logic        frame_err_q;

    // Next-state for synchronizers and the clock filter; the filtered clock
    // only follows the synchronized clock after FILTER_LEN differing samples.
    always_comb begin
        clk_sync_d     = {clk_sync_q[0], bus.kbd_clk};
        dat_sync_d     = {dat_sync_q[0], bus.kbd_dat};
        clk_filt_d     = clk_filt_q;
        clk_filt_dly_d = clk_filt_q;
        filt_cnt_d     = '0;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                clk_filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 4'd1;
            end
        end
    end

    // Conditioning registers; idle line level is high so everything resets to 1.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clk_sync_q     <= 2'b11;
            dat_sync_q     <= 2'b11;
            filt_cnt_q     <= '0;
            clk_filt_q     <= 1'b1;
            clk_filt_dly_q <= 1'b1;
        end else begin
            clk_sync_q     <= clk_sync_d;
            dat_sync_q     <= dat_sync_d;
            filt_cnt_q     <= filt_cnt_d;
            clk_filt_q     <= clk_filt_d;
            clk_filt_dly_q <= clk_filt_dly_d;
        end
    end

    assign fall  = clk_filt_dly_q & ~clk_filt_q;
    assign dat_s = dat_sync_q[1];

    // Frame FSM with registered byte output and status strobes; a fall in the
    // same cycle as an expiring timeout takes priority and restarts the count.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            par_q        <= 1'b0;
            tmo_cnt_q    <= '0;
            dout_q       <= 8'h00;
            dout_new_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            dout_new_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (state_q == S_IDLE) begin
                tmo_cnt_q <= '0;
                if (fall && !dat_s) begin
                    state_q   <= S_DATA;
                    bit_cnt_q <= '0;
                end
            end else if (fall) begin
                tmo_cnt_q <= '0;
                if (state_q == S_DATA) begin
                    shreg_q   <= {dat_s, shreg_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_q <= S_PARITY;
                    end
                end else if (state_q == S_PARITY) begin
                    par_q   <= dat_s;
                    state_q <= S_STOP;
                end else begin
                    state_q <= S_IDLE;
                    if (!dat_s) begin
                        frame_err_q <= 1'b1;
                    end else if (!(^{shreg_q, par_q})) begin
                        parity_err_q <= 1'b1;
                    end else begin
                        dout_q     <= shreg_q;
                        dout_new_q <= 1'b1;
                    end
                end
            end else if (tmo_cnt_q == TMO_LAST) begin
                frame_err_q <= 1'b1;
                state_q     <= S_IDLE;
                tmo_cnt_q   <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_new   = dout_new_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;

endmodule

// File: doc/ps2_frame_rx.md
# ps2_frame_rx

Serial front end of the keyboard path. It synchronizes and de-glitches the PS/2 `kbd_clk`/`kbd_dat` pins and deserializes each 11-bit device-to-host frame. Validated bytes go out as `dout[7:0]` plus a one-cycle `dout_new` strobe; these feed `din`/`din_new` of the scan-code byte recognizer directly. Bad frames are dropped and flagged.

## Interface
- `FILTER_LEN`, 4: consecutive identical synchronized samples required before the filtered clock line changes; range 2..15.
- `TIMEOUT_CYCLES`, 50000: idle cycles allowed between filtered clock falling edges inside a frame (1 ms at 50 MHz); 16-bit counter.
- `clk`, in, 1: system clock, rising edge.
- `resetN`, in, 1: asynchronous active-low reset.
- `kbd_clk`, in, 1: raw PS/2 clock pin, asynchronous.
- `kbd_dat`, in, 1: raw PS/2 data pin, asynchronous.
- `dout`, out, 8: last valid received byte. Held until the next valid frame.
- `dout_new`, out, 1: one-cycle strobe, `dout` updated this cycle.
- `parity_err`, out, 1: one-cycle strobe, frame dropped on odd-parity failure.
- `frame_err`, out, 1: one-cycle strobe, frame dropped on bad stop bit or timeout.

## Operation
- Input conditioning:
  - Both pins pass through a 2-FF synchronizer.
  - `clk_filt` takes the synchronized clock value only after it has held that value for `FILTER_LEN` consecutive cycles. Reset value is 1.
  - `fall` = `clk_filt_d` & ~`clk_filt`, one cycle. Synchronized data is sampled in the `fall` cycle.
- Frame: start(0), D0..D7 LSB first, parity (odd over D0..D7+P), stop(1).
- FSM states:
  - IDLE: on `fall`, if data=0, go to DATA with bit_cnt=0. If data=1, it is a false start; remain in IDLE and flag nothing.
  - DATA: on `fall`, shift data into shreg[7] and shift right; bit_cnt++. Leaving when bit_cnt reaches 7 goes to PARITY.
  - PARITY: on `fall`, latch the parity bit and go to STOP.
  - STOP: on `fall`, evaluate in this order and always return to IDLE:
    - stop=0 → `frame_err`.
    - else if XOR(shreg, P)=0 → `parity_err`.
    - else load `dout`=shreg and assert `dout_new`.
- Timeout:
  - In DATA, PARITY or STOP, a counter clears on every `fall` and increments otherwise.
  - When it reaches `TIMEOUT_CYCLES`, pulse `frame_err` and return to IDLE. No output is produced.
  - The counter is held at 0 in IDLE.
- Exactly one of `dout_new`/`parity_err`/`frame_err` fires per terminated frame; none fire for a false start.
- There is no backpressure. Downstream must accept a byte in the `dout_new` cycle.
- Host-to-device transmission is not supported; both pins are inputs only.

## Timing
- Reset values:
  - `dout`=8'h00; `dout_new`=`parity_err`=`frame_err`=0.
  - FSM=IDLE; shreg, bit_cnt, timeout counter=0.
  - Synchronizers and `clk_filt`/`clk_filt_d`=1.
- Pin-to-`fall` latency: 2 sync cycles + `FILTER_LEN` cycles + 1 edge cycle, i.e. at most `FILTER_LEN`+3 cycles after a clean pin edge.
- Strobes (`dout_new`, `parity_err`, `frame_err`) are registered and assert the cycle after the stop-bit `fall`. Each is high for exactly one cycle.
- A clock glitch shorter than `FILTER_LEN` cycles produces no `fall`.
- Data must be stable at the pin for at least `FILTER_LEN`+3 cycles after the clock falls. PS/2 guarantees ≥15 µs.
- A timeout and a `fall` in the same cycle: `fall` wins and the counter clears.
- Reset mid-frame: all state is cleared immediately with no strobe. The next frame starting with a valid start bit is received normally.
- Back-to-back frames with no idle gap beyond the stop bit are received correctly. The next start bit's `fall` is handled in IDLE.

## Test plan
- Valid frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1; P=0), PS/2 clock at 12.5 kHz → `dout`=0x1C and `dout_new` high for exactly 1 cycle; no error strobes.
- Sequence E0, F0, 74 (P=0, 1, 1) back-to-back → three `dout_new` pulses with `dout`=0xE0, 0xF0, 0x74 in order.
- Frame 0x1C with P=1 → `parity_err` for 1 cycle; no `dout_new`; `dout` keeps its previous value (0x74).
- Frame 0x1C with stop=0 → `frame_err` for 1 cycle; no `dout_new`. Next frame 0x29 → `dout`=0x29.
- Clock stops after 5 bits, then `TIMEOUT_CYCLES` elapse → single `frame_err`, FSM returns to IDLE. Following frame 0xF0 → `dout`=0xF0.
- Low glitch on `kbd_clk` of `FILTER_LEN`-1 cycles in IDLE and inside a frame → no strobes and no bit shift; the surrounding frame 0x1C is still received correctly.
- Assert `resetN` after 4 data bits → all outputs return to reset values at once. Next frame 0x1C → `dout`=0x1C.
